// File: rtl/demux_1to8_deser.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1to8_deser
//  Description : 1-to-8 serial deserialiser. It routes accepted serial bits
//                onto lanes 0..7, with lane 0 first. A completed frame is
//                presented on dout with a valid/ready handshake. While a frame
//                is waiting to be taken, no new bits are accepted. One bubble
//                cycle follows each handshake.
//                Optional build macro: DEMUX_PARITY_EN. When it is defined,
//                each frame carries a 9th serial bit (even parity) and the
//                result is reported on par_err.
//  Revision    : 1.0  initial release
// ============================================================================
module demux_1to8_deser (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [2:0] slot,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready
`ifdef DEMUX_PARITY_EN
    ,
    output logic       par_err
`endif
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_COLLECT = 2'd0;
`ifdef DEMUX_PARITY_EN
    localparam logic [1:0] c_ST_PARITY  = 2'd1;
`endif
    localparam logic [1:0] c_ST_HOLD    = 2'd2;
    localparam logic [2:0] c_LAST_LANE  = 3'd7;

    // ------------------------------------------------------------------------
    // Registers and combinational nets
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [2:0] r_slot;
    logic [7:0] r_shadow;
    logic [7:0] w_shadow_next;
    logic [7:0] r_dout;
    logic       r_dout_valid;
    logic       w_din_ready;
    logic       w_xfer;
    logic       w_data_xfer;
    logic       w_load;
    logic       w_release;
`ifdef DEMUX_PARITY_EN
    logic       r_par_err;
`endif

    // A transfer is the valid/ready handshake on the serial side.
    assign w_xfer      = din_valid & w_din_ready;
    // Only transfers in COLLECT carry data bits. The parity bit never lands in a lane.
    assign w_data_xfer = w_xfer & (r_state == c_ST_COLLECT);
    // The consumer takes the pending frame.
    assign w_release   = (r_state == c_ST_HOLD) & dout_ready;

    // Shadow image with the current serial bit merged into its lane
    always_comb begin
        w_shadow_next         = r_shadow;
        w_shadow_next[r_slot] = din;
    end

    // Next-state, serial-side ready and frame-load strobe
    always_comb begin
        w_state_next = r_state;
        w_din_ready  = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            c_ST_COLLECT: begin
                w_din_ready = 1'b1;
                if (din_valid && (r_slot == c_LAST_LANE)) begin
`ifdef DEMUX_PARITY_EN
                    w_state_next = c_ST_PARITY;
`else
                    w_state_next = c_ST_HOLD;
                    w_load       = 1'b1;
`endif
                end
            end
`ifdef DEMUX_PARITY_EN
            c_ST_PARITY: begin
                w_din_ready = 1'b1;
                if (din_valid) begin
                    w_state_next = c_ST_HOLD;
                    w_load       = 1'b1;
                end
            end
`endif
            c_ST_HOLD: begin
                // din_ready stays low here, including the handshake cycle.
                // That low cycle is the bubble after each frame.
                if (dout_ready) begin
                    w_state_next = c_ST_COLLECT;
                end
            end
            default: begin
                w_state_next = c_ST_COLLECT;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Lane pointer and shadow lanes advance only on data transfers.
    // The slot wraps to 0 after lane 7.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot   <= 3'd0;
            r_shadow <= 8'h00;
        end else if (w_data_xfer) begin
            r_slot   <= r_slot + 3'd1;
            r_shadow <= w_shadow_next;
        end
    end

    // Output frame register. It changes only when a frame loads or on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= 8'h00;
        end else if (w_load) begin
`ifdef DEMUX_PARITY_EN
            r_dout <= r_shadow;
`else
            r_dout <= w_shadow_next;
`endif
        end
    end

`ifdef DEMUX_PARITY_EN
    // Even parity check over the 8 data bits plus the received parity bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else if (w_load) begin
            r_par_err <= (^r_shadow) ^ din;
        end
    end
`endif

    // Frame-valid flag. It is set on load and cleared when the consumer takes the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout_valid <= 1'b0;
        end else if (w_load) begin
            r_dout_valid <= 1'b1;
        end else if (w_release) begin
            r_dout_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign din_ready  = w_din_ready;
    assign slot       = r_slot;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
`ifdef DEMUX_PARITY_EN
    assign par_err    = r_par_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_1to8_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_1to8_deser
//  Description : Self-checking bench for demux_1to8_deser. The bench holds a
//                behavioural model that collects bits into a list and emits
//                frames. Directed scenarios run first, then randomised traffic.
//                The bench honours the DEMUX_PARITY_EN macro.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_demux_1to8_deser;

`ifdef DEMUX_PARITY_EN
    localparam int FRAME_LEN = 9;
`else
    localparam int FRAME_LEN = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       dout_ready = 1'b1;
    logic       din_ready;
    logic [2:0] slot;
    logic [7:0] dout;
    logic       dout_valid;
`ifdef DEMUX_PARITY_EN
    logic       par_err;
`endif

    demux_1to8_deser dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .slot       (slot),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
`ifdef DEMUX_PARITY_EN
        ,
        .par_err    (par_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: a list of received bits plus a "frame pending" flag
    // ------------------------------------------------------------------------
    logic       m_bits [0:8];
    int         m_n = 0;
    bit         m_pending = 1'b0;
    bit         m_init = 1'b0;
    logic [7:0] m_dout = 8'h00;
    logic       m_perr = 1'b0;
    int         cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_init    = 1'b1;
            m_n       = 0;
            m_pending = 1'b0;
            m_dout    = 8'h00;
            m_perr    = 1'b0;
        end else if (m_pending) begin
            if (dout_ready) m_pending = 1'b0;
        end else if (din_valid) begin
            m_bits[m_n] = din;
            m_n++;
            if (m_n == FRAME_LEN) begin
                m_perr = 1'b0;
                for (int k = 0; k < 8; k++) m_dout[k] = m_bits[k];
                for (int k = 0; k < FRAME_LEN; k++) m_perr = m_perr ^ m_bits[k];
                m_pending = 1'b1;
                m_n       = 0;
            end
        end
    end

    // Compare the DUT against the model on every cycle after the first reset
    always @(negedge clk) begin
        if (m_init) begin
            chk("cmp_din_ready", din_ready, !m_pending);
            chk("cmp_slot", slot, m_n % 8);
            chk("cmp_dout_valid", dout_valid, m_pending);
            chk("cmp_dout", dout, m_dout);
`ifdef DEMUX_PARITY_EN
            chk("cmp_par_err", par_err, m_perr);
`endif
        end
    end

    // Record the cycle on which each dout_valid pulse rises
    int rise_q[$];
    bit prev_v = 1'b0;
    always @(negedge clk) begin
        if ((dout_valid === 1'b1) && !prev_v) rise_q.push_back(cyc);
        prev_v = (dout_valid === 1'b1);
    end

    // ------------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        int w;
        w = 0;
        din_valid = 1'b0;
        while (!din_ready && w < 64) begin
            step();
            w++;
        end
        if (!din_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: din_ready got 0 expected 1 at %0t", $time);
        end
        din       = b;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] d, input bit gaps);
        for (int k = 0; k < 8; k++) begin
            if (gaps && k > 0) begin
                step();
                chk("slot_hold_idle", slot, k);
            end
            send_bit(d[k]);
        end
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_data(d, 1'b0);
`ifdef DEMUX_PARITY_EN
        send_bit(^d);
`endif
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk("reset_din_ready", din_ready, 1);
        chk("reset_slot", slot, 0);
        chk("reset_dout", dout, 8'h00);
        chk("reset_dout_valid", dout_valid, 0);

        // Bits 1,1,0,0,1,0,1,1 with continuous valid, consumer always ready
        dout_ready = 1'b1;
        send_frame(8'hD3);
        chk("s1_valid_latency", dout_valid, 1);
        chk("s1_dout", dout, 8'b11010011);
        chk("s1_model_pin", m_dout, 8'hD3);
        step();
        chk("s1_valid_one_cycle", dout_valid, 0);
        chk("s1_ready_after", din_ready, 1);

        // Same frame with valid toggling
        send_data(8'hD3, 1'b1);
`ifdef DEMUX_PARITY_EN
        step();
        send_bit(1'b1);
`endif
        chk("s2_dout", dout, 8'hD3);
        chk("s2_valid", dout_valid, 1);
        step();

        // Stalled consumer. Junk bits offered during HOLD must be refused.
        dout_ready = 1'b0;
        send_frame(8'h5A);
        for (int i = 0; i < 5; i++) begin
            chk("s3_hold_valid", dout_valid, 1);
            chk("s3_hold_din_ready", din_ready, 0);
            chk("s3_hold_dout", dout, 8'h5A);
            din       = 1'b1;
            din_valid = 1'b1;
            step();
            din_valid = 1'b0;
        end
        chk("s3_still_valid", dout_valid, 1);
        dout_ready = 1'b1;
        chk("s3_handshake_bubble", din_ready, 0);
        step();
        chk("s3_resume_valid", dout_valid, 0);
        chk("s3_resume_ready", din_ready, 1);
        send_frame(8'h3C);
        chk("s3_next_dout", dout, 8'h3C);
        chk("s3_next_valid", dout_valid, 1);
        step();

        // Reset in mid-frame discards the partial frame
        for (int k = 0; k < 4; k++) send_bit(1'b1);
        chk("s4_slot_mid", slot, 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s4_slot_reset", slot, 0);
        chk("s4_no_valid", dout_valid, 0);
        chk("s4_ready", din_ready, 1);
        repeat (3) begin
            step();
            chk("s4_no_valid_idle", dout_valid, 0);
        end
        send_frame(8'hA5);
        chk("s4_dout", dout, 8'hA5);
        chk("s4_valid", dout_valid, 1);
        step();

`ifdef DEMUX_PARITY_EN
        // Parity good and parity bad
        send_data(8'h0F, 1'b0);
        send_bit(1'b0);
        chk("s5_dout_good", dout, 8'h0F);
        chk("s5_par_ok", par_err, 0);
        step();
        send_data(8'h0F, 1'b0);
        send_bit(1'b1);
        chk("s5_dout_bad", dout, 8'h0F);
        chk("s5_par_err", par_err, 1);
        step();
`endif

        // Back-to-back frames with the consumer always ready
        repeat (2) step();
        rise_q.delete();
        dout_ready = 1'b1;
        send_frame(8'hFF);
        chk("s6_first_dout", dout, 8'hFF);
        send_frame(8'h00);
        chk("s6_second_dout", dout, 8'h00);
        repeat (2) step();
        chk("s6_pulse_count", rise_q.size(), 2);
        if (rise_q.size() >= 2) chk("s6_pulse_spacing", rise_q[1] - rise_q[0], FRAME_LEN + 1);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            din        = 1'($urandom_range(0, 1));
            din_valid  = ($urandom_range(0, 3) != 0);
            dout_ready = ($urandom_range(0, 2) != 0);
            rst        = ($urandom_range(0, 149) == 0);
            step();
        end
        rst       = 1'b0;
        din_valid = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
